// File: rtl/riscv_pkg.sv
// Shared types for the execute/memory pipeline boundary: widths, control/payload structs,
// and the skid-buffer occupancy states.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_out;
        logic              zero;
        logic              carry;
        logic [XLEN-1:0]   store_data;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        ex_mem_ctrl_t      ctrl;
    } ex_mem_payload_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic br_taken(input ex_mem_payload_t p);
        return p.ctrl.branch & p.zero;
    endfunction

endpackage

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer; in_ready and all outputs come from flops
// so memory-stage back-pressure never forms a combinational path into execute.
module ex_mem_skid_reg
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic              in_zero,
    input  logic              in_carry,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [4:0]        in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu_out,
    output logic              out_zero,
    output logic              out_carry,
    output logic [XLEN-1:0]   out_store_data,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic [4:0]        out_ctrl,
    output logic              out_br_taken,
    output logic [1:0]        occupancy
);

    skid_state_e     state_q, state_d;
    ex_mem_payload_t main_q, main_d;
    ex_mem_payload_t skid_q, skid_d;
    ex_mem_payload_t in_payload;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            br_taken_q, br_taken_d;
    logic            push, pop;

    always_comb begin
        in_payload.alu_out    = in_alu_out;
        in_payload.zero       = in_zero;
        in_payload.carry      = in_carry;
        in_payload.store_data = in_store_data;
        in_payload.pc         = in_pc;
        in_payload.rd         = in_rd;
        in_payload.ctrl       = ex_mem_ctrl_t'(in_ctrl);
    end

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash wins over any same-cycle push/pop; payload regs keep stale data.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = in_payload;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_payload;
                    end else if (push) begin
                        skid_d  = in_payload;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        br_taken_d  = out_valid_d & br_taken(main_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            br_taken_q  <= br_taken_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_alu_out    = main_q.alu_out;
    assign out_zero       = main_q.zero;
    assign out_carry      = main_q.carry;
    assign out_store_data = main_q.store_data;
    assign out_pc         = main_q.pc;
    assign out_rd         = main_q.rd;
    assign out_ctrl       = main_q.ctrl;
    assign out_br_taken   = br_taken_q;
    assign occupancy      = state_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Randomized and directed bench for ex_mem_skid_reg against a queue-based FIFO model.
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic [63:0] alu_out;
        logic        zero;
        logic        carry;
        logic [63:0] store_data;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu_out;
    logic        in_zero;
    logic        in_carry;
    logic [63:0] in_store_data;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic [4:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_alu_out;
    logic        out_zero;
    logic        out_carry;
    logic [63:0] out_store_data;
    logic [63:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_ctrl;
    logic        out_br_taken;
    logic [1:0]  occupancy;

    int     n_checks;
    int     n_fails;
    entry_t model_q[$];

    ex_mem_skid_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_out    (in_alu_out),
        .in_zero       (in_zero),
        .in_carry      (in_carry),
        .in_store_data (in_store_data),
        .in_pc         (in_pc),
        .in_rd         (in_rd),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_out   (out_alu_out),
        .out_zero      (out_zero),
        .out_carry     (out_carry),
        .out_store_data(out_store_data),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_ctrl      (out_ctrl),
        .out_br_taken  (out_br_taken),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic entry_t out_entry();
        entry_t e;
        e = '{alu_out: out_alu_out, zero: out_zero, carry: out_carry, store_data: out_store_data,
              pc: out_pc, rd: out_rd, ctrl: out_ctrl};
        return e;
    endfunction

    // Compare DUT-visible state with the FIFO model (head entry, count, handshake flags).
    task automatic check_model();
        check("out_valid", 256'(out_valid), 256'(model_q.size() != 0));
        check("in_ready", 256'(in_ready), 256'(model_q.size() < 2));
        check("occupancy", 256'(occupancy), 256'(model_q.size()));
        if (model_q.size() != 0) begin
            check("head_payload", 256'(out_entry()), 256'(model_q[0]));
            check("br_taken", 256'(out_br_taken), 256'(model_q[0].ctrl[4] & model_q[0].zero));
        end else begin
            check("br_taken_idle", 256'(out_br_taken), 256'(0));
        end
    endtask

    // Called at posedge+1: check, drive one cycle of inputs, advance model at the edge.
    task automatic step(input logic v, input logic [63:0] alu, input logic z, input logic [4:0] ctrl,
                        input logic ordy, input logic fl);
        entry_t e;
        logic   push, pop;
        check_model();
        in_valid      = v;
        in_alu_out    = alu;
        in_zero       = z;
        in_carry      = 1'($urandom);
        in_store_data = {$urandom, $urandom};
        in_pc         = {$urandom, $urandom};
        in_rd         = 5'($urandom);
        in_ctrl       = ctrl;
        out_ready     = ordy;
        flush         = fl;
        e = '{alu_out: alu, zero: z, carry: in_carry, store_data: in_store_data, pc: in_pc,
              rd: in_rd, ctrl: ctrl};
        push = v && (model_q.size() < 2);
        pop  = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 64'h0, 1'b0, 5'h0, ordy, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_alu_out    = '0;
        in_zero       = 1'b0;
        in_carry      = 1'b0;
        in_store_data = '0;
        in_pc         = '0;
        in_rd         = '0;
        in_ctrl       = '0;
        out_ready     = 1'b0;

        #12;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_occupancy", 256'(occupancy), 256'(0));
        check("rst_payload", 256'(out_entry()), 256'(0));
        check("rst_br_taken", 256'(out_br_taken), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with out_ready held high.
        step(1'b1, 64'h10, 1'b0, 5'h01, 1'b1, 1'b0);
        check("stream_0x10", 256'(out_alu_out), 256'(64'h10));
        check("stream_occ", 256'(occupancy), 256'(1));
        step(1'b1, 64'h20, 1'b0, 5'h01, 1'b1, 1'b0);
        check("stream_0x20", 256'(out_alu_out), 256'(64'h20));
        check("stream_in_ready", 256'(in_ready), 256'(1));
        step(1'b1, 64'h30, 1'b0, 5'h01, 1'b1, 1'b0);
        check("stream_0x30", 256'(out_alu_out), 256'(64'h30));
        check("stream_occ", 256'(occupancy), 256'(1));
        idle(1'b1);
        check("stream_drained", 256'(out_valid), 256'(0));

        // Back-pressure fills both entries, then drains in order.
        step(1'b1, 64'hA, 1'b0, 5'h02, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 5'h02, 1'b0, 1'b0);
        check("bp_occ_full", 256'(occupancy), 256'(2));
        check("bp_in_ready", 256'(in_ready), 256'(0));
        check("bp_head_0xA", 256'(out_alu_out), 256'(64'hA));
        idle(1'b0);
        check("bp_held_0xA", 256'(out_alu_out), 256'(64'hA));
        idle(1'b1);
        check("bp_then_0xB", 256'(out_alu_out), 256'(64'hB));
        check("bp_occ_one", 256'(occupancy), 256'(1));
        idle(1'b1);
        check("bp_empty", 256'(out_valid), 256'(0));

        // Flush while FULL, with a push offered and the consumer ready.
        step(1'b1, 64'h1, 1'b0, 5'h00, 1'b0, 1'b0);
        step(1'b1, 64'h2, 1'b0, 5'h00, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b0, 5'h00, 1'b1, 1'b1);
        check("flush_valid", 256'(out_valid), 256'(0));
        check("flush_occ", 256'(occupancy), 256'(0));
        check("flush_in_ready", 256'(in_ready), 256'(1));
        idle(1'b1);
        idle(1'b1);

        // Branch-taken flag.
        step(1'b1, 64'h40, 1'b1, 5'h10, 1'b1, 1'b0);
        check("br_taken_1", 256'(out_br_taken), 256'(1));
        step(1'b1, 64'h44, 1'b0, 5'h10, 1'b1, 1'b0);
        check("br_taken_0", 256'(out_br_taken), 256'(0));
        step(1'b1, 64'h48, 1'b1, 5'h10, 1'b1, 1'b0);
        idle(1'b1);
        check("br_taken_empty", 256'(out_br_taken), 256'(0));

        // Asynchronous reset while FULL.
        step(1'b1, 64'h55, 1'b1, 5'h10, 1'b0, 1'b0);
        step(1'b1, 64'h66, 1'b0, 5'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_in_ready", 256'(in_ready), 256'(1));
        check("midrst_occ", 256'(occupancy), 256'(0));
        check("midrst_alu_out", 256'(out_alu_out), 256'(0));
        check("midrst_br_taken", 256'(out_br_taken), 256'(0));
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic; stall stability follows from the head check every cycle.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 99) < 60), {$urandom, $urandom}, 1'($urandom),
                 5'($urandom), 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
